// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain clock/data enables.
// Define PS2_TX_TIMEOUT_EN to abort a transfer when the device stops clocking.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, BITS, PARITY, STOP, ACK, WAIT_IDLE} state_t;

    state_t        state_q;
    logic [2:0]    clk_s_q;
    logic [2:0]    data_s_q;
    logic [IW-1:0] inh_q;
    logic [7:0]    sh_q;
    logic          par_q;
    logic [2:0]    idx_q;
    logic          fall;
    logic          abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s_q  <= 3'b111;
            data_s_q <= 3'b111;
        end else begin
            clk_s_q  <= {clk_s_q[1:0], ps2_clk};
            data_s_q <= {data_s_q[1:0], ps2_data};
        end
    end

    assign fall = clk_s_q[2] & ~clk_s_q[1];

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q;
    logic          active;
    assign active = state_q inside {START, BITS, PARITY, STOP, ACK};
    assign abort  = active && !fall && to_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) to_q <= '0;
        else       to_q <= (fall || !active) ? '0 : to_q + TW'(1);
    end
`else
    // Never true: the timeout path is compiled out and error stays low.
    assign abort = TIMEOUT_CYCLES < 0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            error       <= 1'b0;
            inh_q       <= '0;
            sh_q        <= '0;
            par_q       <= 1'b0;
            idx_q       <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                tx_ready    <= 1'b1;
                error       <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (tx_valid) begin
                        state_q     <= INHIBIT;
                        tx_ready    <= 1'b0;
                        sh_q        <= tx_data;
                        par_q       <= ~^tx_data;
                        inh_q       <= IW'(INHIBIT_CYCLES - 1);
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= INHIBIT_CYCLES == 1;
                    end
                    INHIBIT: begin
                        inh_q <= inh_q - IW'(1);
                        if (inh_q == IW'(1)) ps2_data_oe <= 1'b1;
                        if (inh_q == '0) begin
                            state_q    <= START;
                            ps2_clk_oe <= 1'b0;
                        end
                    end
                    START: if (fall) begin
                        state_q     <= BITS;
                        idx_q       <= '0;
                        ps2_data_oe <= ~sh_q[0];
                    end
                    BITS: if (fall) begin
                        idx_q <= idx_q + 3'd1;
                        sh_q  <= sh_q >> 1;
                        if (idx_q == 3'd7) begin
                            state_q     <= PARITY;
                            ps2_data_oe <= ~par_q;
                        end else begin
                            ps2_data_oe <= ~sh_q[1];
                        end
                    end
                    PARITY: if (fall) begin
                        state_q     <= STOP;
                        ps2_data_oe <= 1'b0;
                    end
                    STOP: if (fall) state_q <= ACK;
                    ACK: if (fall) begin
                        state_q <= WAIT_IDLE;
                        ack_ok  <= ~data_s_q[2];
                    end
                    WAIT_IDLE: if (clk_s_q[2] && data_s_q[2]) begin
                        state_q  <= IDLE;
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboarded bench with a PS/2 device model for ps2_host_tx.
module tb_ps2_host_tx;
    localparam int INH = 10;
    localparam int TMO = 100;

    typedef struct packed {
        logic        is_err;
        logic        ack;
        logic [10:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
    logic       tx_ready, done, ack_ok, error;

    exp_t        exp_q[$];
    logic [10:0] act_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_seen = 0;
    bit          have_prev = 0;
    logic        prev_ack = 1'b0;

    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .done(done), .ack_ok(ack_ok), .error(error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            done_seen++;
            if (exp_q.size() == 0) fail("unexpected_done");
            else begin
                e = exp_q.pop_front();
                chk("done_kind", 32'(e.is_err), 0);
                chk("ack_ok", 32'(ack_ok), 32'(e.ack));
                if (act_q.size() == 0) fail("frame_missing");
                else chk("frame", 32'(act_q.pop_front()), 32'(e.frame));
            end
        end
        if (error) begin
            if (exp_q.size() == 0) fail("unexpected_error");
            else begin
                e = exp_q.pop_front();
                chk("error_kind", 32'(e.is_err), 1);
            end
        end
    end

    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2) == 0;
        return {1'b1, par, d, 1'b0};
    endfunction

    // Device clocks n falling edges, sampling the data line just before each one.
    task automatic device(input int n_edges, input bit ack, output logic [10:0] fr, output bit rdy);
        fr  = '0;
        rdy = 0;
        for (int k = 1; k <= n_edges; k++) begin
            repeat (10) begin
                @(negedge clk);
                if (tx_ready) rdy = 1;
            end
            if (k <= 11) fr[k-1] = ps2_data;
            dev_clk = 1'b0;
            repeat (5) @(negedge clk);
            if (k == 11 && ack) dev_data = 1'b0;
            repeat (5) @(negedge clk);
            dev_clk = 1'b1;
            if (k == 12) dev_data = 1'b1;
        end
    endtask

    task automatic accept_and_inhibit(input logic [7:0] d, input bit check_timing);
        int n;
        int rise;
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", 32'(tx_ready), 1);
        if (have_prev) chk("ack_ok_hold", 32'(ack_ok), 32'(prev_ack));
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = ~d;
        n = 0;
        rise = 0;
        while (ps2_clk_oe && n < 1000) begin
            n++;
            if (ps2_data_oe && rise == 0) rise = n;
            if (tx_ready) fail("ready_in_inhibit");
            @(negedge clk);
        end
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (check_timing) begin
            chk("inhibit_len", 32'(n), INH);
            chk("data_oe_rise", 32'(rise), INH);
        end
        chk("start_bit_oe", 32'(ps2_data_oe), 1);
    endtask

    task automatic send(input logic [7:0] d, input bit ack);
        exp_t        e;
        logic [10:0] fr;
        bit          rdy;
        int          ds0;
        int          n;
        accept_and_inhibit(d, 1);
        e.is_err = 1'b0;
        e.ack    = ack;
        e.frame  = model_frame(d);
        exp_q.push_back(e);
        ds0 = done_seen;
        device(12, ack, fr, rdy);
        act_q.push_back(fr);
        chk("ready_low_during", 32'(rdy), 0);
        n = 0;
        while (done_seen == ds0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("done_count", 32'(done_seen - ds0), 1);
        @(negedge clk);
        chk("ready_after_done", 32'(tx_ready), 1);
        have_prev = 1;
        prev_ack  = ack;
    endtask

    initial begin
        logic [10:0] fr;
        bit          rdy;
        int          n;
        repeat (3) @(negedge clk);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("rst_data_oe", 32'(ps2_data_oe), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ack_ok", 32'(ack_ok), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_ready", 32'(tx_ready), 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        send(8'hED, 1);
        send(8'hF4, 1);
        send(8'h00, 0);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        accept_and_inhibit(8'h00, 0);
        device(3, 0, fr, rdy);
        chk("pre_reset_data_oe", 32'(ps2_data_oe), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_clk_oe", 32'(ps2_clk_oe), 0);
        chk("async_rst_data_oe", 32'(ps2_data_oe), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        have_prev = 0;
        repeat (3) @(negedge clk);
        send(8'hFF, 1);

`ifdef PS2_TX_TIMEOUT_EN
        begin
            exp_t e;
            accept_and_inhibit(8'h3C, 0);
            e.is_err = 1'b1;
            e.ack    = 1'b0;
            e.frame  = '0;
            exp_q.push_back(e);
            device(4, 0, fr, rdy);
            n = 10;
            while (!error && n < TMO + 50) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_window", 32'(n >= TMO && n <= TMO + 5), 1);
            chk("timeout_clk_oe", 32'(ps2_clk_oe), 0);
            chk("timeout_data_oe", 32'(ps2_data_oe), 0);
            chk("timeout_ready", 32'(tx_ready), 1);
            repeat (20) @(negedge clk);
        end
`endif

        repeat (20) @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
